// File: rtl/axis_pkg.sv
// axis_pkg: shared defaults and FSM state encoding for the AXI-Stream packet master.
// Contents: default widths/depth used as parameter defaults, and the two-state FSM type.
package axis_pkg;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LEN_W      = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: single-clock first-word-fall-through FIFO feeding the packet output register.
// Ports:
//   aclk, areset_n   clock, synchronous active-low reset (flushes pointers and count)
//   wr_en, wr_data   write strobe/data; a write while full is dropped
//   rd_en            pop the head word (ignored while empty)
//   dout             current head word, valid whenever empty=0
//   count            number of stored words
//   full, empty      decoded from the registered count
module axis_sync_fifo
    import axis_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign full  = count == (AW + 1)'(FIFO_DEPTH);
    assign empty = count == '0;
    assign dout  = mem[rd_ptr];

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_rd)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_wr && !do_rd)
                count <= count + (AW + 1)'(1);
            else if (do_rd && !do_wr)
                count <= count - (AW + 1)'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/axis_m_pkt.sv
// axis_m_pkt: AXI-Stream master that sends a packet of pkt_len words taken from an internal FIFO.
// Ports:
//   aclk, areset_n         clock, synchronous active-low reset (abandons any packet)
//   wr_en, wr_data, full   user FIFO write side; writes while full are dropped
//   start, pkt_len         begin a packet of pkt_len beats (sampled only when idle, 0 ignored)
//   busy                   high from accepted start until the finish cycle
//   tvalid, tready, tdata, tlast   AXI-Stream master interface (registered outputs)
//   finish                 one-cycle pulse in the cycle after the final handshake
module axis_m_pkt
    import axis_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int LEN_W      = DEF_LEN_W
) (
    input  logic              aclk,
    input  logic              areset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    input  logic              start,
    input  logic [LEN_W-1:0]  pkt_len,
    output logic              busy,
    output logic              tvalid,
    input  logic              tready,
    output logic [DATA_W-1:0] tdata,
    output logic              tlast,
    output logic              finish
);
    localparam int AW = $clog2(FIFO_DEPTH);

    state_t            state;
    state_t            state_n;
    logic [LEN_W-1:0]  beats_left;
    logic [LEN_W-1:0]  beats_n;
    logic [LEN_W-1:0]  load_left;
    logic [LEN_W-1:0]  load_n;
    logic              tvalid_n;
    logic [DATA_W-1:0] tdata_n;
    logic              tlast_n;
    logic              busy_n;
    logic              finish_n;
    logic              hs;
    logic              load;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic [AW:0]       unused_count;

    axis_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .aclk     (aclk),
        .areset_n (areset_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (load),
        .dout     (fifo_dout),
        .count    (unused_count),
        .full     (full),
        .empty    (fifo_empty)
    );

    // load_left counts words still to be pulled from the FIFO, beats_left counts
    // beats still to be accepted downstream; tlast is tied to the load count so an
    // underrun gap never shifts its position.
    always_comb begin
        state_n  = state;
        beats_n  = beats_left;
        load_n   = load_left;
        tvalid_n = tvalid;
        tdata_n  = tdata;
        tlast_n  = tlast;
        busy_n   = busy;
        finish_n = 1'b0;
        hs       = tvalid && tready;
        load     = (state == SEND) && (!tvalid || tready) && !fifo_empty && (load_left != '0);
        if (state == IDLE) begin
            if (start && pkt_len != '0) begin
                beats_n = pkt_len;
                load_n  = pkt_len;
                busy_n  = 1'b1;
                state_n = SEND;
            end
        end else begin
            if (hs) begin
                beats_n  = beats_left - LEN_W'(1);
                tvalid_n = 1'b0;
                tlast_n  = 1'b0;
                if (tlast) begin
                    finish_n = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = IDLE;
                end
            end
            if (load) begin
                tdata_n  = fifo_dout;
                tvalid_n = 1'b1;
                tlast_n  = load_left == LEN_W'(1);
                load_n   = load_left - LEN_W'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            state      <= IDLE;
            beats_left <= '0;
            load_left  <= '0;
            tvalid     <= 1'b0;
            tdata      <= '0;
            tlast      <= 1'b0;
            busy       <= 1'b0;
            finish     <= 1'b0;
        end else begin
            state      <= state_n;
            beats_left <= beats_n;
            load_left  <= load_n;
            tvalid     <= tvalid_n;
            tdata      <= tdata_n;
            tlast      <= tlast_n;
            busy       <= busy_n;
            finish     <= finish_n;
        end
    end
endmodule

// File: tb/tb_axis_m_pkt.sv
// tb_axis_m_pkt: self-checking bench for axis_m_pkt against a queue-based model of the word stream.
module tb_axis_m_pkt;
    logic        aclk = 1'b0;
    logic        areset_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        full;
    logic        start = 1'b0;
    logic [7:0]  pkt_len = '0;
    logic        busy;
    logic        tvalid;
    logic        tready = 1'b0;
    logic [31:0] tdata;
    logic        tlast;
    logic        finish;

    logic [31:0] mq[$];
    logic [31:0] late_q[$];
    int          n_chk = 0;
    int          n_pass = 0;

    axis_m_pkt dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .start    (start),
        .pkt_len  (pkt_len),
        .busy     (busy),
        .tvalid   (tvalid),
        .tready   (tready),
        .tdata    (tdata),
        .tlast    (tlast),
        .finish   (finish)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Idle-time write; the model accepts it only if the stream holds fewer than 4 words.
    task automatic wr(input logic [31:0] d);
        @(negedge aclk);
        wr_en = 1'b1;
        wr_data = d;
        if (mq.size() < 4)
            mq.push_back(d);
        @(posedge aclk);
        #1 wr_en = 1'b0;
    endtask

    // Runs one packet, checking every cycle until one cycle past the finish pulse.
    // rmode: 0 tready=1, 1 pattern 1,0,0 repeating, 2 random.
    task automatic run_pkt(input int len, input int rmode, input int late_at, input int poke_at,
                           input int chain, input bit pre, output bit gap_o, output int first_o);
        int beat;
        bit done, pv, hs, last_hs;
        logic pl;
        logic [31:0] pd;
        beat = 0; done = 0; pv = 0; last_hs = 0; pl = 0; pd = '0;
        gap_o = 0; first_o = -1;
        if (!pre) begin
            @(negedge aclk);
            start = 1'b1;
            pkt_len = 8'(len);
        end
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge aclk);
            start = 1'b0;
            wr_en = 1'b0;
            if (last_hs) begin
                chk(finish, 1, "finish_pulse");
                chk(busy, 0, "busy_clear");
                chk(tvalid, 0, "tvalid_after_last");
                chk(tlast, 0, "tlast_after_last");
                if (chain != 0) begin
                    start = 1'b1;
                    pkt_len = 8'(chain);
                end
                done = 1;
            end else begin
                chk(finish, 0, "finish_quiet");
                chk(busy, 1, "busy_hold");
                if (pv) begin
                    chk(tvalid, 1, "hold_valid");
                    chk(tdata, pd, "hold_data");
                    chk(tlast, pl, "hold_last");
                end
                if (tvalid) begin
                    if (first_o < 0)
                        first_o = c;
                    chk(tdata, mq.size() != 0 ? mq[0] : 32'bx, "beat_data");
                    chk(tlast, beat == len - 1, "tlast_pos");
                end else if (beat > 0) begin
                    gap_o = 1;
                end
                tready = rmode == 0 ? 1'b1 : rmode == 1 ? (c % 3 == 0) : ($urandom_range(0, 3) != 0);
                if (c == poke_at) begin
                    start = 1'b1;
                    pkt_len = 8'd7;
                end
                if (late_at >= 0 && c >= late_at && late_q.size() != 0) begin
                    wr_en = 1'b1;
                    wr_data = late_q.pop_front();
                end
                hs = tvalid && tready;
                if (hs) begin
                    void'(mq.pop_front());
                    beat++;
                end
                if (wr_en && mq.size() < 4)
                    mq.push_back(wr_data);
                pv = tvalid && !hs;
                pd = tdata;
                pl = tlast;
                last_hs = hs && beat == len;
            end
        end
        if (!done) begin
            n_chk++;
            $error("FAIL pkt_timeout: observed %0d beats expected %0d", beat, len);
        end
        chk(beat, len, "beat_count");
        if (chain == 0) begin
            @(negedge aclk);
            chk(finish, 0, "finish_single");
            chk(busy, 0, "idle_busy");
        end
    endtask

    initial begin
        bit gap;
        int first;
        int s, k, m, len;
        repeat (3) @(negedge aclk);
        chk(tvalid, 0, "rst_tvalid");
        chk(tdata, 0, "rst_tdata");
        chk(tlast, 0, "rst_tlast");
        chk(finish, 0, "rst_finish");
        chk(busy, 0, "rst_busy");
        chk(full, 0, "rst_full");
        areset_n = 1'b1;

        // reset mid-packet
        wr(32'hB0); wr(32'hB1); wr(32'hB2);
        @(negedge aclk); start = 1'b1; pkt_len = 8'd3; tready = 1'b1;
        @(negedge aclk); start = 1'b0;
        @(negedge aclk);
        chk(tvalid, 1, "rstpkt_first_valid");
        chk(tdata, 32'hB0, "rstpkt_first_data");
        @(negedge aclk); areset_n = 1'b0;
        @(negedge aclk);
        chk(tvalid, 0, "rstpkt_tvalid");
        chk(busy, 0, "rstpkt_busy");
        chk(full, 0, "rstpkt_full");
        chk(finish, 0, "rstpkt_finish");
        areset_n = 1'b1;
        mq.delete();
        repeat (5) begin
            @(negedge aclk);
            chk(finish, 0, "rstpkt_no_finish");
            chk(tvalid, 0, "rstpkt_no_valid");
        end
        wr(32'h77);
        run_pkt(1, 0, -1, -1, 0, 0, gap, first);

        // basic packet with latency check
        wr(32'hA0); wr(32'hA1); wr(32'hA2); wr(32'hA3);
        run_pkt(4, 0, -1, -1, 0, 0, gap, first);
        chk(first, 1, "start_latency");
        chk(gap, 0, "basic_no_gap");

        // back-pressure
        wr(32'hA0); wr(32'hA1); wr(32'hA2); wr(32'hA3);
        run_pkt(4, 1, -1, -1, 0, 0, gap, first);

        // FIFO full and drop
        wr(32'h10); wr(32'h11); wr(32'h12);
        @(negedge aclk); chk(full, 0, "not_full_3");
        wr(32'h13);
        @(negedge aclk); chk(full, 1, "full_after_4");
        wr(32'h14);
        @(negedge aclk); chk(full, 1, "full_after_drop");
        run_pkt(4, 0, -1, -1, 0, 0, gap, first);
        chk(full, 0, "drained_not_full");

        // underrun and leftover
        wr(32'h30);
        late_q = '{32'h31, 32'h32, 32'hEE};
        run_pkt(3, 0, 4, -1, 0, 0, gap, first);
        chk(gap, 1, "underrun_gap");
        run_pkt(1, 0, -1, -1, 0, 0, gap, first);

        // ignored starts, then start in the finish cycle
        wr(32'h50);
        @(negedge aclk); start = 1'b1; pkt_len = 8'd0;
        @(negedge aclk); start = 1'b0;
        repeat (3) begin
            chk(busy, 0, "zero_len_busy");
            chk(tvalid, 0, "zero_len_valid");
            @(negedge aclk);
        end
        wr(32'h51); wr(32'h52); wr(32'h53);
        run_pkt(4, 0, -1, 2, 2, 0, gap, first);
        late_q = '{32'h60, 32'h61};
        run_pkt(2, 0, 1, -1, 0, 1, gap, first);

        // randomized packets
        for (int i = 0; i < 25; i++) begin
            k = $urandom_range(0, 4 - mq.size());
            repeat (k) wr($urandom);
            s = mq.size();
            m = $urandom_range(s == 0 ? 1 : 0, 4 - s);
            late_q.delete();
            repeat (m) late_q.push_back($urandom);
            len = $urandom_range(1, s + m);
            run_pkt(len, 2, $urandom_range(0, 6), -1, 0, 0, gap, first);
            late_q.delete();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/axis_m_pkt.md
Name: axis_m_pkt

Overview:
- AXI-Stream master that feeds the team's AXI-Stream slave receiver.
- User logic pushes 32-bit words into an internal FIFO, then issues `start` with a packet length.
- The block streams exactly that many beats on tdata/tvalid/tlast, honouring tready back-pressure.
- It pulses `finish` when the final beat is accepted.

Parameters:
- DATA_W, 32: tdata/wr_data width.
- FIFO_DEPTH, 4: FIFO entries; power of 2, ≥2.
- LEN_W, 8: width of pkt_len; max packet is 2^LEN_W−1 beats.

Ports:
- aclk, input, 1: clock, all logic on rising edge.
- areset_n, input, 1: synchronous active-low reset.
- wr_en, input, 1: user write strobe into FIFO.
- wr_data, input, DATA_W: user write data.
- full, output, 1: FIFO full; a write is dropped if wr_en=1 while full=1.
- start, input, 1: begin packet; sampled only in IDLE.
- pkt_len, input, LEN_W: beats in packet; sampled with start.
- busy, output, 1: high from accepted start until the cycle finish pulses.
- tvalid, output, 1: AXIS valid.
- tready, input, 1: AXIS ready from the downstream slave.
- tdata, output, DATA_W: AXIS data.
- tlast, output, 1: high on the final beat of the packet.
- finish, output, 1: one-cycle pulse after the last handshake.

Behaviour:
- Reset (areset_n=0 at a clock edge):
  - tvalid=0, tdata=0, tlast=0, finish=0, busy=0, full=0.
  - FIFO flushed (pointers and count = 0); state=IDLE.
  - Applies mid-packet too: the packet is abandoned with no finish pulse.
- FIFO:
  - Write occurs when wr_en && !full.
  - Pop occurs when the output register loads.
  - Simultaneous write and pop: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - full = (count==FIFO_DEPTH), registered with the count.
- FSM states:
  - IDLE
    - start && pkt_len!=0: latch beats_left=pkt_len, busy<=1, go SEND.
    - start with pkt_len==0: ignored.
  - SEND
    - Output register loads when (!tvalid || tready) && FIFO non-empty && load_left!=0.
      - load_left is a second counter, set to pkt_len at start and decremented on each load.
    - Load: tdata<=FIFO head, tvalid<=1, tlast<=(load_left==1).
    - Handshake (tvalid && tready): beats_left decrements.
    - If no new load happens in the handshake cycle, tvalid<=0 and tlast<=0.
    - Handshake with tlast=1: tvalid<=0, tlast<=0, finish<=1, busy<=0, go IDLE.
    - Back-to-back handshakes sustain 1 beat/cycle while the FIFO is non-empty.
- AXIS rules:
  - tvalid never depends combinationally on tready.
  - Once tvalid=1, tvalid, tdata and tlast hold stable until a handshake.
  - FIFO underrun mid-packet: tvalid drops after the handshake and the packet resumes when data arrives; tlast position is unaffected.
- finish:
  - Exactly one-cycle pulse, in the cycle after the last handshake.
  - start asserted in that finish cycle is accepted, since the state is IDLE.
- start while busy: ignored; pkt_len changes while busy: ignored.
- Words in the FIFO beyond pkt_len remain for the next packet.
- Latency: with data present in the FIFO, tvalid rises 2 cycles after start is sampled (1 cycle for IDLE→SEND, 1 cycle for the output register load).
- Counters are LEN_W wide. load_left never decrements below 0, so it does not wrap.

Decomposition:
- Shared package axis_pkg: DATA_W and LEN_W defaults, and FSM state encoding (IDLE=1'b0, SEND=1'b1).
- One sub-module, axis_sync_fifo: parameterised DATA_W/FIFO_DEPTH with wr_en, rd_en, dout, count, full, empty. Its dout reflects the head combinationally (first-word fall-through).
- FSM, counters and output register live in axis_m_pkt.

Test Plan:
- Reset mid-packet:
  - Stimulus: write 3 words, start pkt_len=3, assert areset_n=0 after the first handshake.
  - Required: next cycle tvalid=0, busy=0, full=0, finish never pulses; FIFO empty afterwards.
- Basic packet:
  - Stimulus: write 0xA0,0xA1,0xA2,0xA3; start pkt_len=4; tready=1.
  - Required: 4 consecutive beats, tdata A0..A3, tlast only on A3; finish=1 for one cycle after; busy 1→0.
- Back-pressure:
  - Stimulus: same data with tready toggling 1,0,0,1,...
  - Required: tdata/tvalid/tlast stable during tready=0; no beat lost or duplicated; tlast on the 4th handshake.
- FIFO full and drop:
  - Stimulus: 5 writes 0x10..0x14 with no start.
  - Required: full=1 after the 4th write; 0x14 dropped; a later pkt_len=4 sends 0x10..0x13.
- Underrun and leftovers:
  - Stimulus: 1 word, start pkt_len=3, later write 2 more words plus 1 extra word 0xEE.
  - Required: tvalid gaps while empty; tlast on the 3rd beat; 0xEE remains, and a subsequent pkt_len=1 sends 0xEE with tlast=1.
- Ignored starts:
  - Stimulus: start with pkt_len=0; then start while busy; then start during the finish cycle.
  - Required: the first two have no effect; the third is accepted (busy=1 the next cycle).
